// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the divided-clock period/duty measurement block.
package clk_meas_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Optional 2-flop synchronizer for div_in followed by a rising-edge detector on the sampled signal.
module sync_edge #(
  parameter int SYNC_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic s,
  output logic rise
);

  logic s_prev;

  if (SYNC_EN != 0) begin : g_sync
    logic meta;
    logic sync;
    always_ff @(posedge clk) begin
      if (rst) begin
        meta <= 1'b0;
        sync <= 1'b0;
      end else begin
        meta <= div_in;
        sync <= meta;
      end
    end
    assign s = sync;
  end else begin : g_direct
    assign s = div_in;
  end

  always_ff @(posedge clk) begin
    if (rst) s_prev <= 1'b0;
    else     s_prev <= s;
  end

  assign rise = s & ~s_prev;

endmodule

// File: rtl/clk_div_meas.sv
// Measures the period and high time of a divided clock in clk cycles and tracks lock/mismatch/timeout.
// meas_valid is a one-cycle strobe: period/high_cnt/locked/mismatch are valid in the cycle it is high; there is no ready.
module clk_div_meas
  import clk_meas_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SYNC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic s;
  logic rise;

  sync_edge #(.SYNC_EN(SYNC_EN)) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .div_in (div_in),
    .s      (s),
    .rise   (rise)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] ref_period, ref_period_nxt;
  logic             ref_ok, ref_ok_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             mv_nxt, lk_nxt, mm_nxt, to_nxt;
  logic             period_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      ref_period <= '0;
      ref_ok     <= 1'b0;
      period     <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hcnt       <= hcnt_nxt;
      ref_period <= ref_period_nxt;
      ref_ok     <= ref_ok_nxt;
      period     <= period_nxt;
      high_cnt   <= high_nxt;
      meas_valid <= mv_nxt;
      locked     <= lk_nxt;
      mismatch   <= mm_nxt;
      timeout    <= to_nxt;
    end
  end

  // cnt holds the cycles since the last rise, so at the next rise it already equals the period.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hcnt_nxt       = hcnt;
    ref_period_nxt = ref_period;
    ref_ok_nxt     = ref_ok;
    period_nxt     = period;
    high_nxt       = high_cnt;
    mv_nxt         = 1'b0;
    lk_nxt         = locked;
    mm_nxt         = 1'b0;
    to_nxt         = 1'b0;
    period_match   = ref_ok && (cnt == ref_period);

    if (rise) begin
      cnt_nxt  = ONE;
      hcnt_nxt = ONE;
      unique case (state)
        IDLE: state_nxt = FIRST;
        FIRST: begin
          period_nxt     = cnt;
          high_nxt       = hcnt;
          mv_nxt         = 1'b1;
          ref_period_nxt = cnt;
          ref_ok_nxt     = 1'b1;
          if (period_match) begin
            state_nxt = LOCKED;
            lk_nxt    = 1'b1;
          end
        end
        LOCKED: begin
          period_nxt = cnt;
          high_nxt   = hcnt;
          mv_nxt     = 1'b1;
          if (cnt != ref_period) begin
            mm_nxt         = 1'b1;
            lk_nxt         = 1'b0;
            ref_period_nxt = cnt;
            state_nxt      = FIRST;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      // A rise on the threshold cycle takes the branch above, so a full-scale period still measures.
      if (cnt == CNT_MAX) begin
        to_nxt     = 1'b1;
        lk_nxt     = 1'b0;
        ref_ok_nxt = 1'b0;
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        hcnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + ONE;
        if (s) hcnt_nxt = hcnt + ONE;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_clk_div_meas.sv
// Bench for clk_div_meas: one DUT with the synchronizer and one without, both driven by the same div_in,
// each checked against an edge-timestamp reference model through an expected-record queue.
module tb_clk_div_meas;
  import clk_meas_pkg::*;

  localparam int W  = 8;
  localparam int RW = 2 * W + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div_in = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int SE = (g == 0) ? 1 : 0;

    logic [W-1:0] period, high_cnt;
    logic         meas_valid, locked, mismatch, timeout;
    state_t       dbg_state;

    clk_div_meas #(.CNT_W(W), .SYNC_EN(SE)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .div_in     (div_in),
      .period     (period),
      .high_cnt   (high_cnt),
      .meas_valid (meas_valid),
      .locked     (locked),
      .mismatch   (mismatch),
      .timeout    (timeout),
      .dbg_state  (dbg_state)
    );

    // record layout: {is_timeout, period, high_cnt, locked, mismatch}
    logic [RW-1:0] exp_q[$];
    bit            dh[$];
    int            k = 0;
    int            last_rst = -100;
    int            last_rise = 0;
    int            hsum = 0;
    int            ref_p = 0;
    bit            meas = 1'b0;
    bit            ref_ok = 1'b0;
    bit            lk = 1'b0;
    bit            s_prev = 1'b0;
    logic [W-1:0]  e_period = '0;
    logic [W-1:0]  e_high = '0;

    always @(posedge clk) begin : model
      bit s, rise, mm;
      int p;
      dh.push_back(div_in);
      if (rst) begin
        meas = 1'b0; ref_ok = 1'b0; lk = 1'b0; s_prev = 1'b0;
        last_rst = k; e_period = '0; e_high = '0;
      end else begin
        if (SE != 0) s = (k - 2 > last_rst) ? dh[k-2] : 1'b0;
        else         s = div_in;
        rise = s && !s_prev;
        if (rise) begin
          if (meas) begin
            p  = k - last_rise;
            mm = 1'b0;
            if (lk) begin
              if (p != ref_p) begin mm = 1'b1; lk = 1'b0; end
            end else if (ref_ok && p == ref_p) begin
              lk = 1'b1;
            end
            ref_p = p; ref_ok = 1'b1;
            e_period = W'(p); e_high = W'(hsum);
            exp_q.push_back({1'b0, e_period, e_high, lk, mm});
          end
          meas = 1'b1; last_rise = k; hsum = 1;
        end else if (meas) begin
          if (k - last_rise == (1 << W) - 1) begin
            meas = 1'b0; lk = 1'b0; ref_ok = 1'b0;
            exp_q.push_back({1'b1, e_period, e_high, 1'b0, 1'b0});
          end else if (s) begin
            hsum++;
          end
        end
        s_prev = s;
      end
      k++;
    end

    always @(negedge clk) begin : monitor
      logic [RW-1:0] got, want;
      state_t es;
      es = !meas ? IDLE : (lk ? LOCKED : FIRST);
      total++;
      if ({period, high_cnt, locked, dbg_state} !== {e_period, e_high, lk, es}) begin
        bad++;
        $display("FAIL lane%0d regs t=%0t: got p=%0d h=%0d lk=%0b st=%0d want p=%0d h=%0d lk=%0b st=%0d",
                 g, $time, period, high_cnt, locked, dbg_state, e_period, e_high, lk, es);
      end
      if (meas_valid || timeout || mismatch) begin
        got = {timeout, period, high_cnt, locked, mismatch};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL lane%0d spurious t=%0t: got mv=%0b rec=%h want no output", g, $time, meas_valid, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want || meas_valid !== !want[RW-1]) begin
            bad++;
            $display("FAIL lane%0d record t=%0t: got mv=%0b rec=%h want mv=%0b rec=%h",
                     g, $time, meas_valid, got, !want[RW-1], want);
          end
        end
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL lane%0d missing t=%0t: got no output want rec=%h", g, $time, exp_q[0]);
        exp_q.delete();
      end
    end
  end

  task automatic wave(input int p, input int h, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        div_in = (i < h);
      end
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      div_in = v;
    end
  endtask

  initial begin
    int p, h;
    rst = 1'b1;
    div_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wave(15, 8, 6);
    wave(5, 2, 5);
    wave(3, 1, 8);
    wave(4, 1, 8);
    hold(1'b0, 300);
    wave(15, 8, 4);
    hold(1'b1, 300);
    hold(1'b0, 5);

    wave(15, 8, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      div_in = (i < 8);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    div_in = 1'b0;
    wave(15, 8, 4);

    wave(255, 100, 3);
    hold(1'b0, 3);

    for (int seg = 0; seg < 20; seg++) begin
      p = $urandom_range(2, 24);
      h = $urandom_range(1, p - 1);
      wave(p, h, $urandom_range(2, 5));
    end
    hold(1'b0, 4);
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_meas.md
CLK_DIV_MEAS -- requirements
Module: clk_div_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 8, setting the width of the period and high-time counters.
REQ-002 SHALL have parameter SYNC_EN, default 1. When 1, div_in passes a 2-flop synchronizer. When 0, div_in is used directly.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset. Reset is synchronous and active-high.
REQ-005 SHALL have port div_in, input, 1 bit, the divided clock under measurement, sampled as data.
REQ-006 SHALL have port period, output, CNT_W bits, the last measured rising-to-rising distance in clk cycles.
REQ-007 SHALL have port high_cnt, output, CNT_W bits, the number of clk cycles div_in was sampled high in the last period.
REQ-008 SHALL have port meas_valid, output, 1 bit, a 1-cycle pulse when period and high_cnt update.
REQ-009 SHALL have port locked, output, 1 bit, high while two or more consecutive periods match.
REQ-010 SHALL have port mismatch, output, 1 bit, a 1-cycle pulse when a period differs from the reference while locked.
REQ-011 SHALL have port timeout, output, 1 bit, a 1-cycle pulse when no rising edge arrives within 2^CNT_W-1 cycles.

Function
REQ-012 SHALL define the sampled signal s as the synchronizer output (or div_in when SYNC_EN=0).
REQ-013 SHALL define a rise as s=1 while the previous s=0. The rise is seen 2 cycles after div_in rises when SYNC_EN=1, and 0 cycles after when SYNC_EN=0.
REQ-014 SHALL implement FSM states IDLE, FIRST and LOCKED:
- IDLE waits for the first rise.
- FIRST holds one reference period and waits for a matching period.
- LOCKED is entered after a match.
REQ-015 SHALL load cnt=1 on a rise, then increment cnt by 1 each cycle. On the next rise, period takes the value of cnt at that rise.
REQ-016 SHALL count cycles with s=1 into hcnt, counting from the rise cycle inclusive. hcnt restarts at the rise (the rise cycle counts as 1).
REQ-017 SHALL behave as follows on a rise in IDLE: no output update, start counting, go to FIRST.
REQ-018 SHALL behave as follows on a rise in FIRST: update period/high_cnt, pulse meas_valid, and store ref=new period. If the new period equals the old ref and the old ref is valid, go to LOCKED; otherwise stay in FIRST.
REQ-019 SHALL behave as follows on a rise in LOCKED:
- Update outputs and pulse meas_valid.
- If period≠ref: pulse mismatch in the same cycle as meas_valid, deassert locked, set ref=new period, go to FIRST.
REQ-020 SHALL register all outputs. meas_valid, mismatch and locked change in the cycle after the rise is detected.
REQ-021 SHALL detect timeout when cnt reaches 2^CNT_W-1 without a rise. It then pulses timeout, clears locked and ref-valid, and goes to IDLE.
- cnt never wraps.
- period and high_cnt keep their last values.
REQ-022 SHALL give rise priority when a rise and the timeout threshold coincide (no timeout).
REQ-023 SHALL not update outputs when s stays high continuously; this case times out via REQ-021.
REQ-024 SHALL compare period exactly; no tolerance.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, set state=IDLE and clear cnt, hcnt, ref, ref-valid, period, high_cnt, meas_valid, locked, mismatch, timeout and the synchronizer flops to 0.
REQ-026 SHALL abandon any measurement in progress when reset is asserted mid-period. The first rise after reset release is treated as an IDLE rise.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, FIRST, LOCKED) and the default CNT_W constant in shared package clk_meas_pkg.
REQ-028 SHALL implement the synchronizer plus rise detect as sub-module sync_edge, which outputs s and rise.
REQ-029 SHALL keep counters, FSM and compare logic in clk_div_meas; target size is 120-400 RTL lines.

Verification
REQ-030 SHALL cover divide-by-15: div_in period 15 clk, high 8 cycles -> meas_valid every 15 cycles, period=15, high_cnt=8, locked asserts after the 2nd meas_valid.
REQ-031 SHALL cover divide-by-3 (high 1, low 2): period=3, high_cnt=1, locked after the 2nd meas_valid, no mismatch.
REQ-032 SHALL cover a ratio change: locked on 15, then switch to period 5 -> one mismatch pulse with period=5, locked drops, re-locks after the next period-5 match.
REQ-033 SHALL cover a stuck input: hold div_in=0 (and separately =1) after lock, CNT_W=8 -> one timeout pulse 255 cycles after the last rise, locked=0, state IDLE.
REQ-034 SHALL cover reset mid-operation: assert rst for 1 cycle mid-period while locked -> all outputs 0 next cycle, and the first meas_valid comes only after two rises post-reset.
REQ-035 SHALL cover SYNC_EN=0 with a 1-cycle-high pulse every 4 cycles -> period=4, high_cnt=1, meas_valid aligned 1 cycle after the rise sample.
